// File: rtl/noc_sink.sv
// noc_sink: destination endpoint for one noc_router output port.
// Buffers incoming flits in a DEPTH-entry FIFO, signals full/almost_full back
// to the router, drains at most one flit every DRAIN_DIV cycles, and checks
// valid bit, destination id and per-source sequence numbers of drained flits.
// Flit layout: [0] valid, [2:1] dest, [4:3] src, [WIDTH-1:5] sequence.
// Optional build macro NOC_SINK_STALL_EN: an 8-bit LFSR randomly suppresses
// pop opportunities to create backpressure on the router.
module noc_sink #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int DRAIN_DIV = 1,
    parameter int CW        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       my_id,
    input  logic             drain_en,
    output logic             full,
    output logic             almost_full,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    rx_count,
    output logic [CW-1:0]    dest_err_count,
    output logic [CW-1:0]    seq_err_count,
    output logic [CW-1:0]    inval_count,
    output logic             overflow
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            SW       = WIDTH - 5;
    localparam logic [7:0]    DIV_LAST = 8'(DRAIN_DIV - 1);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_AF   = CNT_FULL - 1'b1;

    typedef enum logic {
        TRK_IDLE,
        TRK_TRACK
    } trk_e;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push, pop, opp, stall;
    logic [7:0]       div_q, div_d;

    // Output/stat registers
    logic             pop_valid_q, pop_valid_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic [CW-1:0]    rx_q, rx_d;
    logic [CW-1:0]    dest_err_q, dest_err_d;
    logic [CW-1:0]    seq_err_q, seq_err_d;
    logic [CW-1:0]    inval_q, inval_d;
    logic             overflow_q, overflow_d;

    // Per-source sequence trackers
    trk_e             trk_q [4];
    trk_e             trk_d [4];
    logic [SW-1:0]    exp_q [4];
    logic [SW-1:0]    exp_d [4];
    logic             seq_err;

    // Head-of-queue flit fields
    logic [WIDTH-1:0] head;
    logic             h_valid;
    logic [1:0]       h_dest;
    logic [1:0]       h_src;
    logic [SW-1:0]    h_seq;

    assign head    = mem_q[rd_ptr_q];
    assign h_valid = head[0];
    assign h_dest  = head[2:1];
    assign h_src   = head[4:3];
    assign h_seq   = head[WIDTH-1:5];

    // Occupancy flags come straight from the registered count; asserting
    // almost_full one entry early lets a write already in flight still land.
    assign full        = (cnt_q == CNT_FULL);
    assign almost_full = (cnt_q >= CNT_AF);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CW'(1) : v;
    endfunction

`ifdef NOC_SINK_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4, stepping every cycle
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Push/pop decisions, pointer/occupancy update and drain divider
    always_comb begin
        opp   = (div_q == 8'd0) && !stall;
        push  = write_in && !full;
        pop   = opp && drain_en && (cnt_q != '0);
        div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Sequence tracker next state: first flit from a source arms the tracker,
    // later flits are compared and the expectation always resyncs to seq+1.
    always_comb begin
        trk_d   = trk_q;
        exp_d   = exp_q;
        seq_err = 1'b0;
        if (pop && h_valid) begin
            case (trk_q[h_src])
                TRK_IDLE: begin
                    exp_d[h_src] = h_seq + SW'(1);
                    trk_d[h_src] = TRK_TRACK;
                end
                TRK_TRACK: begin
                    seq_err      = (h_seq != exp_q[h_src]);
                    exp_d[h_src] = h_seq + SW'(1);
                end
                default: trk_d[h_src] = TRK_IDLE;
            endcase
        end
    end

    // Popped-flit output, statistics and sticky overflow next state
    always_comb begin
        pop_valid_d = pop;
        pop_data_d  = pop ? head : pop_data_q;
        rx_d        = sat_inc(rx_q, pop);
        inval_d     = sat_inc(inval_q, pop && !h_valid);
        dest_err_d  = sat_inc(dest_err_q, pop && h_valid && (h_dest != my_id));
        seq_err_d   = sat_inc(seq_err_q, seq_err);
        overflow_d  = overflow_q | (write_in && full);
    end

    // FIFO storage write; contents need no reset since occupancy governs reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    // Control, output and statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            div_q       <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            rx_q        <= '0;
            dest_err_q  <= '0;
            seq_err_q   <= '0;
            inval_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            rx_q        <= rx_d;
            dest_err_q  <= dest_err_d;
            seq_err_q   <= seq_err_d;
            inval_q     <= inval_d;
            overflow_q  <= overflow_d;
        end
    end

    // Sequence tracker state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                trk_q[i] <= TRK_IDLE;
                exp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                trk_q[i] <= trk_d[i];
                exp_q[i] <= exp_d[i];
            end
        end
    end

    assign pop_valid      = pop_valid_q;
    assign pop_data       = pop_data_q;
    assign rx_count       = rx_q;
    assign dest_err_count = dest_err_q;
    assign seq_err_count  = seq_err_q;
    assign inval_count    = inval_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_noc_sink.sv
// tb_noc_sink: directed bench for noc_sink. u_dut runs DRAIN_DIV=1,
// u_dut4 runs DRAIN_DIV=4 for drain spacing and mid-drain reset.
module tb_noc_sink;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, write_in, drain_en;
    logic [11:0] data_in;
    logic [1:0]  my_id;
    logic        full, almost_full, pop_valid, overflow;
    logic [11:0] pop_data;
    logic [15:0] rx_count, dest_err_count, seq_err_count, inval_count;

    logic        reset4, write4, drain4;
    logic [11:0] data4;
    logic        full4, af4, pop_valid4, ovf4;
    logic [11:0] pop_data4;
    logic [15:0] rx4, derr4, serr4, inv4;

    noc_sink #(.WIDTH(12), .DEPTH(8), .DRAIN_DIV(1), .CW(16)) u_dut (
        .clk(clk), .reset(reset), .write_in(write_in), .data_in(data_in),
        .my_id(my_id), .drain_en(drain_en), .full(full), .almost_full(almost_full),
        .pop_valid(pop_valid), .pop_data(pop_data), .rx_count(rx_count),
        .dest_err_count(dest_err_count), .seq_err_count(seq_err_count),
        .inval_count(inval_count), .overflow(overflow)
    );

    noc_sink #(.WIDTH(12), .DEPTH(8), .DRAIN_DIV(4), .CW(16)) u_dut4 (
        .clk(clk), .reset(reset4), .write_in(write4), .data_in(data4),
        .my_id(my_id), .drain_en(drain4), .full(full4), .almost_full(af4),
        .pop_valid(pop_valid4), .pop_data(pop_data4), .rx_count(rx4),
        .dest_err_count(derr4), .seq_err_count(serr4),
        .inval_count(inv4), .overflow(ovf4)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [11:0] popq[$];
    int          t4[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Collect popped flits and pop times at the falling edge
    always @(negedge clk) begin
        if (pop_valid)  popq.push_back(pop_data);
        if (pop_valid4) t4.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk(input int seq, input int src, input int dst, input bit v);
        logic [6:0] s;
        logic [1:0] sr, d;
        s  = seq[6:0];
        sr = src[1:0];
        d  = dst[1:0];
        return {s, sr, d, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] f);
        write_in = 1'b1;
        data_in  = f;
        tick();
        write_in = 1'b0;
    endtask

    task automatic wr4(input logic [11:0] f);
        write4 = 1'b1;
        data4  = f;
        tick();
        write4 = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int maxc);
        for (int c = 0; c < maxc && popq.size() < n; c++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_t4(input int n, input int maxc);
        for (int c = 0; c < maxc && t4.size() < n; c++) begin
            @(negedge clk);
            #1;
        end
    endtask

    logic af_prev;
    int   seq;

    initial begin
        reset = 1'b1; write_in = 1'b0; data_in = '0; my_id = 2'd0; drain_en = 1'b0;
        reset4 = 1'b1; write4 = 1'b0; data4 = '0; drain4 = 1'b0;
        repeat (3) tick();

        // reset values
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_rx", rx_count, 0);
        chk("rst_dest", dest_err_count, 0);
        chk("rst_seq", seq_err_count, 0);
        chk("rst_inval", inval_count, 0);
        chk("rst_ovf", overflow, 0);

        // 1: ten in-order flits from src 1
        reset = 1'b0; reset4 = 1'b0; drain_en = 1'b1;
        for (int i = 0; i < 10; i++) wr(mk(i, 1, 0, 1));
        wait_pops(10, 30);
        chk("t1_npop", popq.size(), 10);
        for (int i = 0; i < 10 && i < popq.size(); i++)
            chk($sformatf("t1_pop%0d", i), popq[i], mk(i, 1, 0, 1));
        chk("t1_rx", rx_count, 10);
        chk("t1_dest", dest_err_count, 0);
        chk("t1_seq", seq_err_count, 0);
        chk("t1_inval", inval_count, 0);
        chk("t1_ovf", overflow, 0);

        // 2: writer honouring almost_full with one cycle of latency
        popq.delete();
        drain_en = 1'b0;
        af_prev  = 1'b0;
        seq      = 10;
        for (int i = 0; i < 20; i++) begin
            write_in = !af_prev;
            data_in  = mk(seq, 1, 0, 1);
            if (!af_prev) seq++;
            af_prev = almost_full;
            tick();
        end
        write_in = 1'b0;
        chk("t2_full", full, 1);
        chk("t2_af", almost_full, 1);
        chk("t2_ovf", overflow, 0);
        chk("t2_nopop", popq.size(), 0);
        drain_en = 1'b1;
        tick();
        chk("t2_full_drop", full, 0);
        chk("t2_first_pv", pop_valid, 1);
        wait_pops(8, 30);
        chk("t2_npop", popq.size(), 8);
        for (int i = 0; i < 8 && i < popq.size(); i++)
            chk($sformatf("t2_pop%0d", i), popq[i], mk(10 + i, 1, 0, 1));

        // 3: writes into a full FIFO are dropped and flag overflow
        popq.delete();
        drain_en = 1'b0;
        for (int i = 18; i < 26; i++) wr(mk(i, 1, 0, 1));
        chk("t3_full", full, 1);
        chk("t3_ovf0", overflow, 0);
        write_in = 1'b1;
        data_in  = mk(7'h55, 3, 0, 1);
        tick();
        tick();
        chk("t3_ovf1", overflow, 1);
        chk("t3_still_full", full, 1);
        drain_en = 1'b1;
        tick();
        write_in = 1'b0;
        chk("t3_drop_with_pop", full, 0);
        chk("t3_ovf2", overflow, 1);
        wait_pops(8, 30);
        chk("t3_npop", popq.size(), 8);
        for (int i = 0; i < 8 && i < popq.size(); i++)
            chk($sformatf("t3_pop%0d", i), popq[i], mk(18 + i, 1, 0, 1));
        chk("t3_ovf_sticky", overflow, 1);

        // 4: src 2 sequence gap, then wrap through all-ones
        popq.delete();
        wr(mk(0, 2, 0, 1)); wr(mk(1, 2, 0, 1)); wr(mk(2, 2, 0, 1));
        wr(mk(5, 2, 0, 1)); wr(mk(6, 2, 0, 1));
        wait_pops(5, 20);
        chk("t4_npop", popq.size(), 5);
        chk("t4_seq_gap", seq_err_count, 1);
        popq.delete();
        for (int s = 7; s < 128; s++) wr(mk(s, 2, 0, 1));
        wr(mk(0, 2, 0, 1));
        wr(mk(1, 2, 0, 1));
        wait_pops(123, 200);
        chk("t4_npop_wrap", popq.size(), 123);
        chk("t4_seq_wrap", seq_err_count, 1);
        chk("t4_rx", rx_count, 154);
        if (popq.size() > 0) chk("t4_last", popq[popq.size()-1], mk(1, 2, 0, 1));

        // 5: wrong destination, then an invalid flit whose other checks are skipped
        popq.delete();
        wr(mk(0, 3, 3, 1));
        wr(mk(50, 3, 3, 0));
        wait_pops(2, 20);
        chk("t5_dest", dest_err_count, 1);
        chk("t5_inval", inval_count, 1);
        chk("t5_seq", seq_err_count, 1);
        chk("t5_rx", rx_count, 156);
        if (popq.size() > 1) chk("t5_inval_data", popq[1], mk(50, 3, 3, 0));

        // 6: DRAIN_DIV=4 spacing, then reset in the middle of a drain
        for (int i = 0; i < 4; i++) wr4(mk(i, 0, 0, 1));
        drain4 = 1'b1;
        wait_t4(4, 40);
        chk("t6_npop", t4.size(), 4);
        for (int i = 1; i < 4 && i < t4.size(); i++)
            chk($sformatf("t6_gap%0d", i), t4[i] - t4[i-1], 4);
        chk("t6_rx", rx4, 4);
        drain4 = 1'b0;
        t4.delete();
        for (int i = 4; i < 8; i++) wr4(mk(i, 0, 0, 1));
        drain4 = 1'b1;
        wait_t4(2, 30);
        chk("t6_pv_before_rst", pop_valid4, 1);
        reset4 = 1'b1;
        #1;
        chk("t6_rst_pv", pop_valid4, 0);
        chk("t6_rst_data", pop_data4, 0);
        chk("t6_rst_rx", rx4, 0);
        chk("t6_rst_full", full4, 0);
        chk("t6_rst_af", af4, 0);
        chk("t6_rst_ovf", ovf4, 0);
        chk("t6_rst_errs", {derr4, serr4 | inv4}, 0);
        repeat (2) tick();
        reset4 = 1'b0;
        repeat (16) tick();
        chk("t6_no_more_pops", t4.size(), 2);
        chk("t6_rx_after", rx4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_sink.md
Name: noc_sink

Overview:
- Destination endpoint attached to one output port of noc_router.
- Accepts flits on the router's write-out / data-out pair and buffers them in a local FIFO.
- Drives full/almost_full back to the router as its readFull/read_almostfull inputs.
- Drains the FIFO at a throttled rate, checks each flit's valid bit, destination field and per-source sequence number, and exposes statistics counters.

Parameters:
- WIDTH, 12: flit width.
- Flit layout: [0] valid, [2:1] dest id, [4:3] src id, [WIDTH-1:5] sequence count (SW = WIDTH-5 bits).
- DEPTH, 8: FIFO entries, power of two, minimum 4.
- DRAIN_DIV, 1: pop at most one flit every DRAIN_DIV cycles; range 1..255.
- CW, 16: statistics counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- write_in  in  1  router writeOut for this port
- data_in  in  WIDTH  router dataOut for this port
- my_id  in  2  this endpoint's id, compared to dest field
- drain_en  in  1  permit popping
- full  out  1  FIFO holds DEPTH entries
- almost_full  out  1  FIFO holds >= DEPTH-1 entries
- pop_valid  out  1  one-cycle pulse when a flit is popped
- pop_data  out  WIDTH  flit popped, valid with pop_valid
- rx_count  out  CW  flits popped
- dest_err_count  out  CW  popped flits with dest != my_id
- seq_err_count  out  CW  popped flits with sequence mismatch
- inval_count  out  CW  popped flits with bit0 == 0
- overflow  out  1  sticky: write_in seen while full

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - FIFO empty; full=0, almost_full=0.
  - pop_valid=0, pop_data=0, all counters 0, overflow=0.
  - Drain divider count=0; all four source trackers in IDLE.
- full and almost_full are combinational from the registered occupancy. Asserting almost_full at DEPTH-1 guarantees that a write already in flight when the router sees almost_full still lands.
- Push:
  - write_in=1 and not full: data_in is stored at the write pointer next edge.
  - write_in=1 and full: the flit is dropped and overflow is set (sticky until reset), even if a pop occurs in the same cycle.
- Drain divider:
  - Counts 0..DRAIN_DIV-1 and wraps.
  - A pop opportunity occurs when the divider is 0; the divider still advances while drain_en=0.
- Pop:
  - Occurs on an opportunity with drain_en=1 and FIFO not empty.
  - Registered output: pop_valid=1 and pop_data = head on the following cycle.
  - One-cycle latency from the opportunity edge.
  - Empty FIFO: no pop, pop_valid=0.
- Simultaneous push and pop when not full: occupancy unchanged and both operations complete. Pointers are log2(DEPTH) bits and wrap naturally.
- Checks per popped flit, all updated in the same cycle as pop_valid:
  - rx_count increments.
  - bit0 == 0: inval_count increments; dest and sequence checks are skipped.
  - dest != my_id: dest_err_count increments.
  - Sequence tracker indexed by src, two states:
    - IDLE: store expected = seq+1 (mod 2^SW) and go to TRACKING; no error.
    - TRACKING: if seq != expected, seq_err_count increments. expected becomes seq+1 in either case (resync).
    - Wrap from all-ones to 0 is not an error.
- Counters saturate at 2^CW-1.
- Reset mid-operation discards all FIFO contents and statistics immediately.

Optional Feature:
- Macro: NOC_SINK_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle.
  - A pop opportunity is suppressed whenever lfsr[0]==1, producing pseudo-random backpressure on the router.
- Not defined: no LFSR; pops depend only on the divider and drain_en.

Test Plan:
1. Reset, my_id=0, drain_en=1, DRAIN_DIV=1; inject flits src=1 seq 0..9 dest=0 valid=1 -> 10 pop_valid pulses in order; rx_count=10, all error counters 0, overflow=0.
2. drain_en=0, writer obeys almost_full protocol, 20 attempted writes, DEPTH=8 -> exactly 8 stored; full=1 and almost_full=1; overflow=0. Then drain_en=1 -> 8 pops, full deasserts after the first pop.
3. Force write_in=1 while full -> overflow=1 and stays 1; occupancy remains 8; dropped flit never appears on pop_data.
4. src=2 sequence 0,1,2,5,6 -> seq_err_count=1. Next, src=2 seq from 2^SW-1 to 0 -> no additional error.
5. One flit with dest=3 and one with bit0=0 (my_id=0) -> dest_err_count=1, inval_count=1, rx_count increments by 2.
6. DRAIN_DIV=4, FIFO preloaded with 4 flits -> pop_valid pulses exactly 4 cycles apart. Assert reset between the 2nd and 3rd pop -> all outputs return to reset values and no further pops occur.
